shift_add_mul: RTL and testbench

- Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit retired per clock.
- Serves as the additive counterpart to the GCD subtractor datapath.
- Feeds the LCM path, which computes A*B ahead of division by the GCD.
- Valid/ready handshake on both input and output sides; one operation in flight at a time.

---
 rtl/gcd_pkg.sv | 22 ++
 rtl/add_cout.sv | 15 +
 rtl/shift_add_mul.sv | 106 ++++++++++
 tb/tb_shift_add_mul.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD/LCM arithmetic datapath.
//   WIDTH_DEF   : default operand width
//   CNT_W_DEF   : iteration counter width for the default operand width
//   mul_state_t : control states of the sequential shift-and-add multiplier
//   cnt_w()     : iteration counter width for an arbitrary operand width
package gcd_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  // Enough bits to count 0..w-1, never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/add_cout.sv
// Combinational unsigned WIDTH-bit adder with carry out.
// Additive twin of the GCD subtractor; reusable across the GCD/LCM datapath.
//   a, b : WIDTH-bit unsigned addends
//   sum  : WIDTH+1-bit result, sum[WIDTH] is the carry out
module add_cout #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Produces the A*B term consumed by the LCM path ahead of the GCD division.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands A, B valid
//   in_ready  : block is idle and accepts operands
//   A         : WIDTH-bit unsigned multiplicand
//   B         : WIDTH-bit unsigned multiplier
//   out_valid : product valid, held until out_ready
//   out_ready : consumer accepts product
//   P         : 2*WIDTH-bit unsigned product, zero whenever out_valid is low
module shift_add_mul
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t         state, state_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  // Upper WIDTH+1 bits hold the running partial product (plus carry),
  // lower WIDTH bits hold the not-yet-retired multiplier bits.
  logic [2*WIDTH:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     hi_nxt;
  logic [2*WIDTH:0]   pre_shift;

  // After every right shift acc[2*WIDTH] is zero, so adding the multiplicand
  // to acc[2*WIDTH-1:WIDTH] with carry out covers the full WIDTH+1-bit field.
  add_cout #(
    .WIDTH(WIDTH)
  ) u_add (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .b   (mcand),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    hi_nxt    = acc[0] ? sum : acc[2*WIDTH:WIDTH];
    pre_shift = {hi_nxt, acc[WIDTH-1:0]};

    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_nxt = A;
          acc_nxt   = {{(WIDTH+1){1'b0}}, B};
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        acc_nxt = pre_shift >> 1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // Gate the product so partial accumulator contents never reach P.
  assign P         = out_valid ? acc[2*WIDTH-1:0] : '0;

endmodule

// File: tb/tb_shift_add_mul.sv
module tb_shift_add_mul;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] P;

  int n_cmp = 0;
  int n_bad = 0;

  shift_add_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) until out_valid, counting edges after the accept edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Caller is at #1 after a rising edge. Returns P at the handshake and latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                        output logic [2*W-1:0] p, output int lat);
    int g;
    logic [2*W-1:0] held;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("in_ready_before_op", 64'(in_ready), 64'd1);
    in_valid = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom;
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    wait_valid(lat);
    held = P;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_P", P, held);
    end
    p = P;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [W-1:0]   ra, rb;
    int lat;

    tbl[0] = '{32'd3,         32'd5,         64'd15};
    tbl[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
    tbl[2] = '{32'd0,         32'h12345678,  64'd0};
    tbl[3] = '{32'h12345678,  32'd0,         64'd0};
    tbl[4] = '{32'd1,         32'd1,         64'd1};
    tbl[5] = '{32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF};
    tbl[6] = '{32'hFFFFFFFF,  32'd2,         64'h00000001_FFFFFFFE};
    tbl[7] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000};
    tbl[8] = '{32'h0000FFFF,  32'h0000FFFF,  64'h00000000_FFFE0001};
    tbl[9] = '{32'd1,         32'hFFFFFFFF,  64'h00000000_FFFFFFFF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_P", P, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, no stalls.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, 0, p, lat);
      chk($sformatf("tbl%0d_P", i), p, tbl[i].p);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(W));
    end

    // Backpressure with operands presented while busy, then a simultaneous
    // out_ready/in_valid handshake.
    in_valid = 1'b1; A = 32'h10000; B = 32'h10000;
    @(posedge clk); #1;
    A = 32'd7; B = 32'd7;
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'(W));
    chk("bp_P", P, 64'h1_00000000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_P", P, 64'h1_00000000);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    A = 32'd11; B = 32'd13; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("sim_hs_valid", 64'(out_valid), 64'd0);
    chk("sim_hs_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sim_accept_ready", 64'(in_ready), 64'd0);
    wait_valid(lat);
    chk("sim_lat", 64'(lat), 64'(W));
    chk("sim_P", P, 64'd143);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset mid-operation.
    in_valid = 1'b1; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_P", P, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd6, 32'd7, 0, p, lat);
    chk("post_rst_P", p, 64'd42);
    chk("post_rst_lat", 64'(lat), 64'(W));

    // Random pairs with random output stalls and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 50 == 0) ra = '1;
      run_op(ra, rb, $urandom_range(0, 2), p, lat);
      chk("rand_P", p, 64'(ra) * 64'(rb));
      chk("rand_lat", 64'(lat), 64'(W));
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
